led_ctrl_multi: RTL
===================

# led_ctrl_multi

Parametrised successor to the two-LED push-button controller. It drives `NUM_LED` LED channels from a single fabric clock (CCC GL0) and one raw push-button. A debounced press steps the block through six display modes: off, on, slow blink, fast blink, PWM dim and chase. It sits between the clock/reset conditioning (CCC lock ANDed with power-on reset) and the board LED pins.

## Interface
- `NUM_LED`, default 2: number of LED channels, ≥1.
- `TICK_DIV`, default 50000: CLK cycles per timebase tick (1 ms at 50 MHz), ≥2.
- `DEBOUNCE_T`, default 20: consecutive ticks of stable input required to accept a new level, ≥1.
- `SLOW_T`, default 500: ticks per half-period in slow blink.
- `FAST_T`, default 125: ticks per half-period in fast blink, and per chase step.
- `PWM_BITS`, default 4: width of the PWM counter.
- `PWM_DUTY`, default 4: dim-mode on-count out of 2^PWM_BITS, range 0..2^PWM_BITS.

Ports:
- `CLK`, in, 1: fabric clock; all state is on the rising edge.
- `RESETn`, in, 1: asynchronous active-low reset.
- `PB_SW`, in, 1: raw push-button, asynchronous, active-low (0 = pressed).
- `LED`, out, NUM_LED: LED drive, active-high, registered.
- `MODE`, out, 3: current mode code, registered.

## Operation
- **Synchroniser:** two-flop synchroniser on `PB_SW`; both flops reset to 1.
- **Prescaler:** counter runs 0..TICK_DIV-1 and wraps. `tick` is a one-cycle pulse in the cycle where the count equals TICK_DIV-1.
- **Debouncer:** stable level `pb_db` resets to 1.
  - On `tick`, if the synchronised input ≠ `pb_db`, the counter increments. When it reaches DEBOUNCE_T, `pb_db` takes the synchronised value and the counter clears.
  - On `tick`, if the synchronised input = `pb_db`, the counter clears.
  - `press` is a one-cycle pulse in the cycle after `pb_db` goes 1→0. Release generates no event. A held button yields exactly one press.
- **Mode FSM:** OFF=0, ON=1, SLOW=2, FAST=3, DIM=4, CHASE=5. Each `press` advances one state; CHASE wraps to OFF. Codes 6 and 7 are unreachable and recover to OFF on the next cycle.
- **On mode entry:**
  - Blink tick counter clears.
  - Blink phase is set to 1 (LEDs lit).
  - Chase index is set to 0.
- **SLOW/FAST:** blink phase toggles when the tick counter reaches SLOW_T or FAST_T respectively; the counter then clears. In FAST the counter uses a compare of FAST_T.
- **CHASE:** the index advances every FAST_T ticks and wraps from NUM_LED-1 to 0. With NUM_LED=1, LED[0] stays lit.
- **DIM:** free-running PWM_BITS counter increments every CLK, resets to 0. Lit iff counter < PWM_DUTY. PWM_DUTY=0 means always dark; PWM_DUTY=2^PWM_BITS means always lit.
- **LED next-state per mode:**
  - OFF: all 0.
  - ON: all 1.
  - SLOW/FAST: all equal to blink phase.
  - DIM: all equal to the PWM compare.
  - CHASE: one-hot at the chase index.

## Timing
- **Reset values** (asynchronous, all registers):
  - `LED`=0, `MODE`=0.
  - Prescaler, debounce, blink and PWM counters = 0.
  - `pb_db`=1, blink phase=0, chase index=0.
- **Press path:** `PB_SW` edge → 2 cycles of synchronisation → accepted on the DEBOUNCE_T-th consecutive stable tick → `press` 1 cycle later → `MODE` updates 1 cycle after `press` → `LED` reflects the new mode 1 cycle after `MODE`.
- **Rejected input:** any bounce shorter than DEBOUNCE_T ticks is ignored.
- **Blink period:** exactly 2×SLOW_T or 2×FAST_T ticks, measured from mode entry.
- **LED latency:** `LED` is 1 cycle behind the internal state; there is no combinational path from `PB_SW` to `LED`.
- **Simultaneous events:** `press` coinciding with a blink or chase step means the mode change wins, and entry values are loaded.
- **Reset mid-operation:** `RESETn` low at any time returns all outputs to reset values immediately. A button held through reset release produces no press until it has been released and pressed again.

## Test plan
Bench parameters: NUM_LED=4, TICK_DIV=4, DEBOUNCE_T=3, SLOW_T=8, FAST_T=2, PWM_BITS=4, PWM_DUTY=4.

- **Reset:** assert `RESETn`=0 mid-CHASE → `LED`=0000 and `MODE`=0 in the same cycle, held until release.
- **Debounce:** pulse `PB_SW` low for 2 ticks (8 CLK), then release → `MODE` stays 0. Hold low for 20 CLK → `MODE`=1 and `LED`=1111; release → `MODE` stays 1.
- **Mode sequence and wrap:** six clean presses → `MODE` goes 1,2,3,4,5,0.
- **SLOW blink:** in SLOW, `LED`=1111 for 32 CLK, then 0000 for 32 CLK, repeating.
- **DIM duty:** in DIM, `LED`=1111 for exactly 4 of every 16 CLK. With PWM_DUTY=0, `LED` stays 0000.
- **CHASE:** `LED` goes 0001, 0010, 0100, 1000, 0001, changing every 8 CLK. A press exactly on a step boundary → `MODE`=0, `LED`=0000.

Source files
------------

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED controller: debounced push-button cycles through
// off / on / slow blink / fast blink / PWM dim / chase display modes.
module led_ctrl_multi #(
  parameter int unsigned NUM_LED    = 2,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DEBOUNCE_T = 20,
  parameter int unsigned SLOW_T     = 500,
  parameter int unsigned FAST_T     = 125,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned PWM_DUTY   = 4
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               PB_SW,
  output logic [NUM_LED-1:0] LED,
  output logic [2:0]         MODE
);

  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_ON    = 3'd1,
    M_SLOW  = 3'd2,
    M_FAST  = 3'd3,
    M_DIM   = 3'd4,
    M_CHASE = 3'd5
  } mode_t;

  localparam int unsigned PW   = $clog2(TICK_DIV);
  localparam int unsigned DW   = $clog2(DEBOUNCE_T + 1);
  localparam int unsigned BMAX = (SLOW_T > FAST_T) ? SLOW_T : FAST_T;
  localparam int unsigned BW   = $clog2(BMAX + 1);
  localparam int unsigned CW   = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

  localparam logic [PW-1:0]     TICK_END = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]     DB_END   = DW'(DEBOUNCE_T - 1);
  localparam logic [BW-1:0]     SLOW_END = BW'(SLOW_T - 1);
  localparam logic [BW-1:0]     FAST_END = BW'(FAST_T - 1);
  localparam logic [CW-1:0]     LAST_IDX = CW'(NUM_LED - 1);
  localparam logic [PWM_BITS:0] DUTY     = (PWM_BITS + 1)'(PWM_DUTY);

  logic sync1, sync2;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= PB_SW;
      sync2 <= sync1;
    end
  end

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == TICK_END);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) presc <= '0;
    else         presc <= tick ? '0 : presc + 1'b1;
  end

  logic [DW-1:0] db_cnt;
  logic          pb_db, pb_db_d, started, armed, press;

  // A button held through reset must not count as a press: presses are only
  // honoured once a released level has been sampled on a tick after the
  // synchroniser has flushed its reset value (from the second tick onward).
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      db_cnt  <= '0;
      pb_db   <= 1'b1;
      pb_db_d <= 1'b1;
      started <= 1'b0;
      armed   <= 1'b0;
    end else begin
      pb_db_d <= pb_db;
      if (tick) begin
        started <= 1'b1;
        if (started && sync2) armed <= 1'b1;
        if (sync2 != pb_db) begin
          if (db_cnt == DB_END) begin
            pb_db  <= sync2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  assign press = pb_db_d & ~pb_db & armed;

  mode_t mode, mode_nx;

  always_comb begin
    mode_nx = M_OFF;
    case (mode)
      M_OFF:   mode_nx = M_ON;
      M_ON:    mode_nx = M_SLOW;
      M_SLOW:  mode_nx = M_FAST;
      M_FAST:  mode_nx = M_DIM;
      M_DIM:   mode_nx = M_CHASE;
      default: mode_nx = M_OFF;
    endcase
  end

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [CW-1:0] chase_idx;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mode      <= M_OFF;
      blink_cnt <= '0;
      phase     <= 1'b0;
      chase_idx <= '0;
    end else if (press) begin
      mode      <= mode_nx;
      blink_cnt <= '0;
      phase     <= 1'b1;
      chase_idx <= '0;
    end else begin
      case (mode)
        M_OFF, M_ON, M_DIM: begin
        end
        M_SLOW: begin
          if (tick) begin
            if (blink_cnt == SLOW_END) begin
              phase     <= ~phase;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        M_FAST: begin
          if (tick) begin
            if (blink_cnt == FAST_END) begin
              phase     <= ~phase;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        M_CHASE: begin
          if (tick) begin
            if (blink_cnt == FAST_END) begin
              blink_cnt <= '0;
              chase_idx <= (chase_idx == LAST_IDX) ? '0 : chase_idx + 1'b1;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        default: mode <= M_OFF;
      endcase
    end
  end

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Extra MSB lets a duty of 2^PWM_BITS mean permanently lit.
  assign pwm_on = ({1'b0, pwm_cnt} < DUTY);

  logic [NUM_LED-1:0] led_nx;

  always_comb begin
    led_nx = '0;
    case (mode)
      M_ON:           led_nx = '1;
      M_SLOW, M_FAST: led_nx = {NUM_LED{phase}};
      M_DIM:          led_nx = {NUM_LED{pwm_on}};
      M_CHASE: begin
        for (int unsigned i = 0; i < NUM_LED; i++) led_nx[i] = (chase_idx == CW'(i));
      end
      default:        led_nx = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) LED <= '0;
    else         LED <= led_nx;
  end

  assign MODE = mode;

endmodule
